// File: rtl/adder_arbiter_pkg.sv
// Shared constants for the two-client adder arbiter: FSM encoding and requester IDs.
package adder_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

  // Round-robin pick among two requesters; on a tie the one not granted last wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    logic pick;
    case (valid)
      2'b01:   pick = REQ0;
      2'b10:   pick = REQ1;
      2'b11:   pick = ~last;
      default: pick = REQ0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_grant2.sv
// Two-way round-robin grant; purely combinational so it can front any shared resource.
module rr_grant2
  import adder_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (valid != 2'b00) begin
      grant_valid = 1'b1;
      grant_id    = rr_pick(valid, last);
    end else begin
      grant_valid = 1'b0;
      grant_id    = REQ0;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH-bit adder between two valid/ready requesters with round-robin
// arbitration; the tagged result is registered and held until the consumer takes it.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_carry
);

  logic [0:0]       r_state;
  logic             r_last;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic             r_resp_carry;
  logic [WIDTH-1:0] r_resp_sum;

  logic             w_grant_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_total;

  rr_grant2 u_rr_grant2 (
    .valid       ({req1_valid, req0_valid}),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // Readies are gated by rst so nothing can be accepted during a reset cycle.
  always_comb begin
    w_accept   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (r_state == ST_IDLE) && w_grant_valid) begin
      w_accept   = 1'b1;
      req0_ready = (w_grant_id == REQ0);
      req1_ready = (w_grant_id == REQ1);
    end else begin
      w_accept   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_comb begin
    w_a = req0_a;
    w_b = req0_b;
    if (w_grant_id == REQ1) begin
      w_a = req1_a;
      w_b = req1_b;
    end else begin
      w_a = req0_a;
      w_b = req0_b;
    end
  end

  assign w_total = {1'b0, w_a} + {1'b0, w_b};

  // FSM, round-robin pointer and result registers; operands are sampled only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last       <= REQ1;
      r_resp_valid <= 1'b0;
      r_resp_id    <= REQ0;
      r_resp_carry <= 1'b0;
      r_resp_sum   <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_HOLD;
            r_last       <= w_grant_id;
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_grant_id;
            r_resp_carry <= w_total[WIDTH];
            r_resp_sum   <= w_total[WIDTH-1:0];
          end
        end
        ST_HOLD: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_sum   = r_resp_sum;
  assign resp_carry = r_resp_carry;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: the driver pushes expected responses, a monitor
// pops and compares them on every response handshake.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_ready, resp_id, resp_carry;
  logic [3:0] resp_sum;

  int         n_cmp  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  logic       tb_last;
  logic [5:0] sb[$];

  adder_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: {id, carry, sum} must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {26'd0, resp_id, resp_carry, resp_sum}, 32'hFFFF_FFFF);
      end else begin
        chk("resp", {26'd0, resp_id, resp_carry, resp_sum}, {26'd0, sb.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the HOLD cycle.
  task automatic send(input logic v0, input logic v1,
                      input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] a1, input logic [3:0] b1,
                      input logic keep, output int acc_cyc);
    logic       eid;
    logic       got;
    logic [4:0] s;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    eid = (v0 && v1) ? ~tb_last : v1;
    got = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready === 1'b1 || req1_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else begin
      chk("grant", {30'd0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
      acc_cyc = cyc;
      s = eid ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
      sb.push_back({eid, s});
      tb_last = eid;
      @(posedge clk); #1;
      if (!keep) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      chk("latency", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc, prev, hs;
    rst = 1'b1; resp_ready = 1'b1; tb_last = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;

    // Reset: all outputs zero, and no ready even with valids present.
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outs", {25'd0, resp_valid, resp_id, resp_carry, resp_sum, req0_ready, req1_ready}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("idle_outs", {30'd0, resp_valid, req0_ready | req1_ready}, 32'd0);
    @(posedge clk); #1;

    // Single request 3+4, then an overflowing 0xF+0x2 from requester 1.
    send(1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 4'd0, 1'b0, acc);
    send(1'b0, 1'b1, 4'd0, 4'd0, 4'hF, 4'h2, 1'b0, acc);

    // Contention: grants alternate 0,1,0,1 with one accept every two cycles.
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, 4'(i + 1), 4'(2 * i), 4'(i + 9), 4'(3 * i), 1'b1, acc);
      if (prev >= 0) chk("rr_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: tie goes to req0 (5+6); result and readies frozen for 5 cycles.
    resp_ready = 1'b0;
    send(1'b1, 1'b1, 4'd5, 4'd6, 4'd9, 4'd9, 1'b1, acc);
    req0_a = 4'h0; req1_a = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {25'd0, resp_valid, resp_id, resp_carry, resp_sum, req0_ready, req1_ready},
          {25'd0, 1'b1, 1'b0, 1'b0, 4'hB, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    chk("hs_no_accept", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk); #1;
    send(1'b1, 1'b1, 4'd5, 4'd6, 4'd9, 4'd9, 1'b0, acc);
    chk("accept_after_hs", 32'(acc - hs), 32'd1);

    // Reset while holding a result: it is discarded and req0 wins the next tie.
    resp_ready = 1'b0;
    send(1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'd1, 1'b0, acc);
    void'(sb.pop_back());
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    tb_last = 1'b1;
    @(negedge clk);
    chk("rst_clears_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    send(1'b1, 1'b1, 4'd7, 4'd7, 4'd2, 4'd3, 1'b0, acc);

    // Exhaustive operand sweep through requester 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(1'b1, 1'b0, 4'(a), 4'(b), 4'd0, 4'd0, 1'b0, acc);
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
